shift_collect_8_bit: RTL
========================

Name: shift_collect_8_bit

Overview:
- Sequential receiving end of the 8-bit shifter's bit-bucket stream.
- Captures bits shifted out on bb_left or bb_right, one per accepted cycle, and reassembles them into a byte in original bit order.
- Presents the byte on a double-buffered parallel output with a valid/ready handshake.
- Lets the datapath recover data shifted out over multi-cycle shift sequences.

Parameters:
- WIDTH, 8, assembled word width; count register is $clog2(WIDTH)+1 bits.

Ports:
- clk  input  1  rising-edge clock, the block's only clock.
- rst_n  input  1  synchronous active-low reset.
- bit_in  input  1  serial bit from the shifter bit bucket.
- bit_valid  input  1  bit_in is accepted this cycle; no input backpressure.
- select  input  1  source direction, shifter encoding:
  - 0 = left-shift bucket, MSB first.
  - 1 = right-shift bucket, LSB first.
- flush  input  1  abandon the partial word.
- out_ready  input  1  consumer accepts Q this cycle.
- Q  output  WIDTH  assembled word, holding register.
- q_valid  output  1  Q holds an unconsumed word.
- count  output  4  bits collected in the current partial word (0..7).
- overrun  output  1  sticky: a completed word was dropped.

Behaviour:
- Reset: synchronous, active-low, sampled on the clk rising edge; clk is the only clock.
- Reset values:
  - Q=0, q_valid=0, count=0, overrun=0.
  - Accumulator acc=0, direction latch dir=0, state EMPTY.
- Reset mid-word or with q_valid=1 discards everything, with no output activity.
- Collector FSM, two states:
  - EMPTY (count=0): on bit_valid and no flush, latch dir<=select, insert bit, count<=1, go to COLLECT.
  - COLLECT (count 1..WIDTH-1): each bit_valid inserts a bit and increments count.
  - On the WIDTH-th bit, word completes, count<=0, go to EMPTY.
- select is sampled only on the first bit of a word. Changes mid-word are ignored until the word completes.
- Insertion:
  - dir=0: acc<={acc[WIDTH-2:0],bit_in}, so the first bit ends at the MSB.
  - dir=1: acc<={bit_in,acc[WIDTH-1:1]}, so the first bit ends at the LSB.
- Completion cycle: the assembled word includes the bit accepted that cycle.
  - If q_valid=0, or q_valid=1 and out_ready=1: Q<=word, and q_valid=1 on the next edge.
  - Latency is 1 cycle from the last bit to q_valid.
- Handshake:
  - Transfer occurs on q_valid&&out_ready.
  - q_valid clears the following cycle unless a word completes in the same cycle. In that case Q reloads and q_valid stays 1 (back-to-back, no bubble).
  - Q is stable while q_valid=1 and out_ready=0.
- Overrun: word completes while q_valid=1 and out_ready=0.
  - The new word is discarded and Q is retained.
  - overrun<=1 and stays set until flush or reset.
- flush=1:
  - acc<=0, count<=0, dir<=0, overrun<=0, go to EMPTY.
  - Q and q_valid are unaffected, and a handshake in the same cycle still completes.
  - flush together with bit_valid: flush wins and the bit is dropped.
- bit_valid=0: no state change besides the handshake.
- count wraps WIDTH-1 to 0 only via completion and never exceeds WIDTH-1.

Test Plan:
- Reset then idle: rst_n=0 for 2 cycles with bit_valid=1 -> Q=0x00, q_valid=0, count=0, overrun=0 throughout.
- MSB-first assembly: select=0, bits 1,0,1,1,0,0,1,0 on 8 consecutive cycles, out_ready=1 -> Q=0xB2, q_valid=1 exactly one cycle after the 8th bit, count returns to 0.
- LSB-first assembly plus mid-word select toggle: select=1 on the first bit, toggled on bits 3-5, bits 0,1,0,0,1,1,0,1 -> Q=0xB2, with the toggle ignored.
- Back-to-back and stall: two words 0xA5 then 0x3C (select=0, continuous), out_ready=1 -> q_valid stays 1 across both, Q shows 0xA5 then 0x3C with no bubble.
  - Repeat with out_ready=0 -> Q holds 0xA5 and overrun=1 one cycle after the 16th bit.
- Flush: 5 bits of 0xFF, then flush=1 with bit_valid=1, then 8 bits of 0x0F (select=0) -> count 5 to 0, no valid asserted, and the final Q=0x0F.
- Reset mid-word: 4 bits accepted, then rst_n=0 for 1 cycle, then 8 bits of 0x81 -> Q=0x81, proving no stale bits remain.

Source files
------------

// File: rtl/shift_collect_8_bit.sv
// Serial-to-parallel collector for the shifter bit-bucket stream: rebuilds a
// word in original bit order and hands it out through a valid/ready holding register.
module shift_collect_8_bit #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     bit_in,
  input  logic                     bit_valid,
  input  logic                     select,
  input  logic                     flush,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         Q,
  output logic                     q_valid,
  output logic [$clog2(WIDTH):0]   count,
  output logic                     overrun
);
  localparam int CW = $clog2(WIDTH) + 1;

  typedef enum logic {EMPTY, COLLECT} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc, acc_nxt, word, q_nxt;
  logic             dir, dir_nxt, ins_dir;
  logic [CW-1:0]    count_nxt;
  logic             q_valid_nxt, overrun_nxt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= EMPTY;
      acc     <= '0;
      dir     <= 1'b0;
      count   <= '0;
      Q       <= '0;
      q_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      dir     <= dir_nxt;
      count   <= count_nxt;
      Q       <= q_nxt;
      q_valid <= q_valid_nxt;
      overrun <= overrun_nxt;
    end
  end

  // The first bit of a word uses the live select; later bits use the latched direction.
  assign ins_dir = (state == EMPTY) ? select : dir;
  assign word    = ins_dir ? {bit_in, acc[WIDTH-1:1]} : {acc[WIDTH-2:0], bit_in};

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    dir_nxt     = dir;
    count_nxt   = count;
    q_nxt       = Q;
    q_valid_nxt = q_valid;
    overrun_nxt = overrun;

    if (q_valid && out_ready) q_valid_nxt = 1'b0;

    if (flush) begin
      state_nxt   = EMPTY;
      acc_nxt     = '0;
      dir_nxt     = 1'b0;
      count_nxt   = '0;
      overrun_nxt = 1'b0;
    end else if (bit_valid) begin
      acc_nxt = word;
      case (state)
        EMPTY: begin
          dir_nxt   = select;
          count_nxt = CW'(1);
          state_nxt = COLLECT;
        end
        COLLECT: begin
          if (count == CW'(WIDTH-1)) begin
            count_nxt = '0;
            state_nxt = EMPTY;
            // A full holding register that is not draining this cycle drops the new word.
            if (!q_valid || out_ready) begin
              q_nxt       = word;
              q_valid_nxt = 1'b1;
            end else begin
              overrun_nxt = 1'b1;
            end
          end else begin
            count_nxt = count + CW'(1);
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end
endmodule
